// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - command bytes, FSM state type and field sizes for the UART loader
package uart_loader_pkg;

    localparam logic [7:0] CMD_INSN = 8'hA1;
    localparam logic [7:0] CMD_DATA = 8'hA2;
    localparam logic [7:0] CMD_RUN  = 8'hA5;
    localparam logic [7:0] CMD_HALT = 8'hA0;

    localparam int ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CKSUM,
        ST_RUNWAIT
    } ld_state_t;

endpackage

// File: rtl/uart_loader_timeout.sv
// rtl/uart_loader_timeout.sv - reloadable down-counter with a single-cycle expiry pulse
module uart_loader_timeout #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // A reload in the same cycle always wins, so a byte arriving on the last idle cycle is never lost.
    assign expire_o = en_i & ~load_i & (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed UART command parser emitting insn/data word writes and core run control
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int RUN_DELAY      = 100,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int LEN_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_rd,
    input  logic [7:0]  rx_data,
    output logic [31:0] insn_addr,
    output logic [31:0] insn_din,
    output logic        insn_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_din,
    output logic        data_we,
    output logic        run,
    output logic        busy,
    output logic        err_cksum,
    output logic        err_timeout,
    output logic        err_cmd
);

    localparam int LEN_BYTES = LEN_W / 8;
    localparam int CNT_MAX   = (TIMEOUT_CYCLES > RUN_DELAY) ? TIMEOUT_CYCLES : RUN_DELAY;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    ld_state_t         state_q, state_d;
    logic              rx_rd_q;
    logic              tgt_q, tgt_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [31:0]       insn_addr_q, insn_addr_d, insn_din_q, insn_din_d;
    logic [31:0]       data_addr_q, data_addr_d, data_din_q, data_din_d;
    logic              insn_we_q, insn_we_d, data_we_q, data_we_d;
    logic              run_q, run_d;
    logic              err_cksum_q, err_cksum_d, err_timeout_q, err_timeout_d, err_cmd_q, err_cmd_d;

    logic              byte_v, in_frame, tmo_load, tmo_expire;
    logic [CNT_W-1:0]  tmo_val;
    logic [31:0]       shifted;

    assign byte_v   = rx_rd & ~rx_rd_q;
    assign in_frame = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CKSUM);
    // Bytes during RUNWAIT are dropped, so they must not restart the run delay either.
    assign tmo_load = byte_v && (state_q != ST_RUNWAIT);
    assign tmo_val  = (state_q == ST_IDLE && rx_data == CMD_RUN) ? CNT_W'(RUN_DELAY - 1)
                                                                 : CNT_W'(TIMEOUT_CYCLES - 1);
    assign shifted  = {rx_data, buf_q[31:8]};

    uart_loader_timeout #(.W(CNT_W)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmo_load),
        .load_val_i (tmo_val),
        .en_i       (state_q != ST_IDLE),
        .expire_o   (tmo_expire)
    );

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        bcnt_d        = bcnt_q;
        buf_d         = buf_q;
        base_d        = base_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        insn_addr_d   = insn_addr_q;
        insn_din_d    = insn_din_q;
        data_addr_d   = data_addr_q;
        data_din_d    = data_din_q;
        insn_we_d     = 1'b0;
        data_we_d     = 1'b0;
        run_d         = run_q;
        err_cksum_d   = err_cksum_q;
        err_timeout_d = err_timeout_q;
        err_cmd_d     = err_cmd_q;

        unique case (state_q)
            ST_IDLE: if (byte_v) begin
                if (rx_data == CMD_INSN || rx_data == CMD_DATA || rx_data == CMD_RUN ||
                    rx_data == CMD_HALT) begin
                    err_cksum_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    err_cmd_d     = 1'b0;
                end else begin
                    err_cmd_d = 1'b1;
                end
                if (rx_data == CMD_INSN || rx_data == CMD_DATA) begin
                    tgt_d   = (rx_data == CMD_DATA);
                    run_d   = 1'b0;
                    bcnt_d  = 2'd0;
                    sum_d   = 8'd0;
                    state_d = ST_ADDR;
                end else if (rx_data == CMD_RUN) begin
                    state_d = ST_RUNWAIT;
                end else if (rx_data == CMD_HALT) begin
                    run_d = 1'b0;
                end
            end
            ST_ADDR: if (byte_v) begin
                buf_d  = shifted;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'(ADDR_BYTES - 1)) begin
                    base_d  = shifted;
                    bcnt_d  = 2'd0;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: if (byte_v) begin
                buf_d  = shifted;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'(LEN_BYTES - 1)) begin
                    len_d   = shifted[31 -: LEN_W];
                    idx_d   = '0;
                    bcnt_d  = 2'd0;
                    state_d = (shifted[31 -: LEN_W] != '0) ? ST_PAYLOAD : ST_CKSUM;
                end
            end
            ST_PAYLOAD: if (byte_v) begin
                buf_d  = shifted;
                sum_d  = sum_q + rx_data;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    if (tgt_q) begin
                        data_we_d   = 1'b1;
                        data_addr_d = base_q;
                        data_din_d  = shifted;
                    end else begin
                        insn_we_d   = 1'b1;
                        insn_addr_d = base_q;
                        insn_din_d  = shifted;
                    end
                    base_d = base_q + 32'd4;
                    idx_d  = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = ST_CKSUM;
                    end
                end
            end
            ST_CKSUM: if (byte_v) begin
                if (rx_data != sum_q) begin
                    err_cksum_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_RUNWAIT: if (tmo_expire) begin
                run_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_frame && tmo_expire) begin
            err_timeout_d = 1'b1;
            bcnt_d        = 2'd0;
            state_d       = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rx_rd_q       <= 1'b0;
            tgt_q         <= 1'b0;
            bcnt_q        <= 2'd0;
            buf_q         <= '0;
            base_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            insn_addr_q   <= '0;
            insn_din_q    <= '0;
            data_addr_q   <= '0;
            data_din_q    <= '0;
            insn_we_q     <= 1'b0;
            data_we_q     <= 1'b0;
            run_q         <= 1'b0;
            err_cksum_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cmd_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_rd_q       <= rx_rd;
            tgt_q         <= tgt_d;
            bcnt_q        <= bcnt_d;
            buf_q         <= buf_d;
            base_q        <= base_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            insn_addr_q   <= insn_addr_d;
            insn_din_q    <= insn_din_d;
            data_addr_q   <= data_addr_d;
            data_din_q    <= data_din_d;
            insn_we_q     <= insn_we_d;
            data_we_q     <= data_we_d;
            run_q         <= run_d;
            err_cksum_q   <= err_cksum_d;
            err_timeout_q <= err_timeout_d;
            err_cmd_q     <= err_cmd_d;
        end
    end

    assign insn_addr   = insn_addr_q;
    assign insn_din    = insn_din_q;
    assign insn_we     = insn_we_q;
    assign data_addr   = data_addr_q;
    assign data_din    = data_din_q;
    assign data_we     = data_we_q;
    assign run         = run_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_cksum   = err_cksum_q;
    assign err_timeout = err_timeout_q;
    assign err_cmd     = err_cmd_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - randomized frame stimulus checked against a queue-based write model
module tb_uart_loader;

    localparam int RUN_DELAY = 100;
    localparam int TMO       = 50;
    localparam int LEN_W     = 16;

    logic        clk = 1'b0;
    logic        reset, rx_rd;
    logic [7:0]  rx_data;
    logic [31:0] insn_addr, insn_din, data_addr, data_din;
    logic        insn_we, data_we, run, busy, err_cksum, err_timeout, err_cmd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        tgt;
        logic [31:0] addr;
        logic [31:0] din;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [31:0] fw[$];
    logic        run_after_cmd;

    uart_loader #(.RUN_DELAY(RUN_DELAY), .TIMEOUT_CYCLES(TMO), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .rx_rd(rx_rd), .rx_data(rx_data),
        .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
        .run(run), .busy(busy), .err_cksum(err_cksum), .err_timeout(err_timeout),
        .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (insn_we) obs_q.push_back({1'b0, insn_addr, insn_din});
        if (data_we) obs_q.push_back({1'b1, data_addr, data_din});
    end

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
        rx_data = b;
        rx_rd   = 1'b1;
        @(posedge clk);
        #1;
        rx_rd = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Model: every complete payload word becomes one write at base + 4*k on the selected port.
    task automatic send_frame(input logic tgt, input logic [31:0] base, input logic bad_ck);
        logic [7:0]       sum;
        logic [LEN_W-1:0] len;
        logic [31:0]      w;
        sum = 8'd0;
        len = LEN_W'(fw.size());
        send_byte(tgt ? 8'hA2 : 8'hA1);
        run_after_cmd = run;
        for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8]);
        for (int i = 0; i < LEN_W / 8; i++) send_byte(len[8*i +: 8]);
        for (int k = 0; k < fw.size(); k++) begin
            w = fw[k];
            for (int i = 0; i < 4; i++) begin
                sum = sum + w[8*i +: 8];
                send_byte(w[8*i +: 8]);
            end
            exp_q.push_back({tgt, base + 32'(4 * k), w});
        end
        send_byte(bad_ck ? (sum ^ 8'h5A) : sum);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_words(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom());
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rx_rd   = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({insn_addr, insn_din, insn_we, data_addr, data_din, data_we, run, busy,
             err_cksum, err_timeout, err_cmd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ia=%h id=%h da=%h dd=%h ctl=%b expected all zero",
                     insn_addr, insn_din, data_addr, data_din,
                     {insn_we, data_we, run, busy, err_cksum, err_timeout, err_cmd});
        end
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_insn_load();
        fw.delete();
        fw.push_back(32'h11223344);
        fw.push_back(32'hAABBCCDD);
        send_frame(1'b0, 32'h0000_0100, 1'b0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL insn_load_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL insn_load_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({err_cksum, err_timeout, err_cmd, busy} !== 4'b0) begin
            errors++;
            $display("FAIL insn_load_flags: got %b expected 0000", {err_cksum, err_timeout, err_cmd, busy});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_data_bad_cksum();
        fw.delete();
        fw.push_back(32'h01020304);
        send_frame(1'b1, 32'h0, 1'b1);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {1'b1, 32'h0, 32'h01020304}) begin
            errors++;
            $display("FAIL data_load_write: got %0d writes first=%h expected 1 write %h",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, {1'b1, 32'h0, 32'h01020304});
        end
        checks++;
        if (err_cksum !== 1'b1) begin
            errors++;
            $display("FAIL data_cksum_err: err_cksum=%b expected 1", err_cksum);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_run();
        send_byte(8'hA5);
        checks++;
        if (err_cksum !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_cmd_clear: err_cksum=%b busy=%b expected 0 1", err_cksum, busy);
        end
        for (int k = 2; k <= RUN_DELAY; k++) begin
            if (k == 10) begin
                rx_data = 8'h7F;
                rx_rd   = 1'b1;
            end
            if (k == 12) rx_rd = 1'b0;
            @(posedge clk);
            #1;
            if (k == RUN_DELAY - 1) begin
                checks++;
                if (run !== 1'b0) begin
                    errors++;
                    $display("FAIL run_early: run=%b at cycle %0d expected 0", run, k);
                end
            end
        end
        checks++;
        if (run !== 1'b1 || busy !== 1'b0 || err_cmd !== 1'b0) begin
            errors++;
            $display("FAIL run_rise: run=%b busy=%b err_cmd=%b expected 1 0 0", run, busy, err_cmd);
        end
        rand_words(2);
        send_frame(1'b0, $urandom(), 1'b0);
        checks++;
        if (run_after_cmd !== 1'b0) begin
            errors++;
            $display("FAIL run_drop_on_load: run=%b expected 0", run_after_cmd);
        end
        checks++;
        if (obs_q !== exp_q) begin
            errors++;
            $display("FAIL run_load_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        send_byte(8'hA1);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hEE);
        send_byte(8'hDD);
        for (int k = 2; k <= TMO; k++) begin
            @(posedge clk);
            #1;
            if (k == TMO - 1) begin
                checks++;
                if (err_timeout !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_early: err_timeout=%b busy=%b expected 0 1", err_timeout, busy);
                end
            end
        end
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL timeout_expire: err_timeout=%b busy=%b writes=%0d expected 1 0 0",
                     err_timeout, busy, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_bad_cmd_and_empty();
        send_byte(8'h7F);
        checks++;
        if (err_cmd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_cmd: err_cmd=%b busy=%b expected 1 0", err_cmd, busy);
        end
        fw.delete();
        send_frame(1'b1, $urandom(), 1'b0);
        checks++;
        if (obs_q.size() !== 0 || {err_cksum, err_timeout, err_cmd} !== 3'b0) begin
            errors++;
            $display("FAIL empty_frame: writes=%0d errs=%b expected 0 000",
                     obs_q.size(), {err_cksum, err_timeout, err_cmd});
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA2);
        for (int i = 0; i < 4; i++) send_byte(8'h10 * 8'(i));
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i));
        checks++;
        if (obs_q.size() !== 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: writes=%0d busy=%b expected 1 1", obs_q.size(), busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({insn_addr, insn_din, insn_we, data_addr, data_din, data_we, run, busy,
             err_cksum, err_timeout, err_cmd} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: da=%h dd=%h busy=%b expected all zero", data_addr, data_din, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs_q.delete();
        rand_words(3);
        send_frame(1'b1, $urandom(), 1'b0);
        checks++;
        if (obs_q !== exp_q || err_cksum !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_reload: got %0d writes err_cksum=%b expected %0d 0",
                     obs_q.size(), err_cksum, exp_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random_frames();
        logic        tgt, bad;
        logic [31:0] base;
        for (int f = 0; f < 6; f++) begin
            tgt  = 1'($urandom_range(0, 1));
            bad  = 1'($urandom_range(0, 1));
            base = (f == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            rand_words((f == 0) ? 4 : $urandom_range(1, 5));
            send_frame(tgt, base, bad);
            checks++;
            if (obs_q !== exp_q) begin
                errors++;
                $display("FAIL rand_frame%0d_writes: got %0d writes expected %0d", f, obs_q.size(), exp_q.size());
            end
            checks++;
            if (err_cksum !== bad || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_frame%0d_cksum: err_cksum=%b busy=%b expected %b 0", f, err_cksum, busy, bad);
            end
            obs_q.delete();
            exp_q.delete();
        end
        send_byte(8'hA0);
        checks++;
        if (run !== 1'b0 || err_cksum !== 1'b0) begin
            errors++;
            $display("FAIL halt: run=%b err_cksum=%b expected 0 0", run, err_cksum);
        end
    endtask

    initial begin
        test_reset();
        test_insn_load();
        test_data_bad_cksum();
        test_run();
        test_timeout();
        test_bad_cmd_and_empty();
        test_reset_mid();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
